// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared CPU memory-port definitions: FSM states, requester indices, arbitration pick
package cpu_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic REQ_IF  = 1'b0;
  localparam logic REQ_MEM = 1'b1;

  // On contention the requester that was not granted last wins.
  function automatic logic pick_owner(input logic req0, input logic req1, input logic last);
    if (req0 && req1) return ~last;
    return req1;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - requester and shared-port signal bundle for the memory port arbiter
interface mem_port_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req,    m1_req;
  logic          m0_wr,     m1_wr;
  logic [AW-1:0] m0_addr,   m1_addr;
  logic [DW-1:0] m0_wdata,  m1_wdata;
  logic          m0_gnt,    m1_gnt;
  logic          m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata,  m1_rdata;

  logic          s_req;
  logic          s_wr;
  logic [AW-1:0] s_addr;
  logic [DW-1:0] s_wdata;
  logic          s_addr_ok;
  logic          s_data_ok;
  logic [DW-1:0] s_rdata;

  // master: the arbiter itself; slave: requesters plus the memory-side bridge
  modport master (
    input  m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
    input  s_addr_ok, s_data_ok, s_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    output s_req, s_wr, s_addr, s_wdata
  );

  modport slave (
    output m0_req, m1_req, m0_wr, m1_wr, m0_addr, m1_addr, m0_wdata, m1_wdata,
    output s_addr_ok, s_data_ok, s_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
    input  s_req, s_wr, s_addr, s_wdata
  );
endinterface

// File: rtl/mux2x1_32.sv
// rtl/mux2x1_32.sv - 32-bit 2:1 multiplexer cell
module mux2x1_32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        sel,
  output logic [31:0] y
);
  assign y = sel ? b : a;
endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter and ADDR/DATA sequencer for the shared memory port
module mem_port_arbiter
  import cpu_defs::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input logic                clk,
  input logic                rst,
  mem_port_arbiter_if.master bus
);

  state_t        state;
  logic          owner;
  logic          last_owner;
  logic          wr_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;

  logic          any_req;
  logic          next_owner;
  logic [31:0]   sel_addr;
  logic [31:0]   sel_wdata;
  logic          gnt_fire;
  logic          done;

  assign any_req    = bus.m0_req | bus.m1_req;
  assign next_owner = pick_owner(bus.m0_req, bus.m1_req, last_owner);

  mux2x1_32 u_addr_mux (
    .a   (bus.m0_addr),
    .b   (bus.m1_addr),
    .sel (next_owner),
    .y   (sel_addr)
  );

  mux2x1_32 u_wdata_mux (
    .a   (bus.m0_wdata),
    .b   (bus.m1_wdata),
    .sel (next_owner),
    .y   (sel_wdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      owner      <= REQ_IF;
      last_owner <= REQ_IF;
      wr_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            owner      <= next_owner;
            last_owner <= next_owner;
            wr_q       <= next_owner ? bus.m1_wr : bus.m0_wr;
            addr_q     <= sel_addr;
            wdata_q    <= sel_wdata;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (bus.s_addr_ok) state <= bus.s_data_ok ? IDLE : DATA;
        end
        DATA: begin
          if (bus.s_data_ok) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Handshake responses are decoded from the state so reset drops them at once.
  assign gnt_fire = (state == ADDR) && bus.s_addr_ok;
  assign done     = (gnt_fire && bus.s_data_ok) || ((state == DATA) && bus.s_data_ok);

  assign bus.s_req   = (state == ADDR);
  assign bus.s_wr    = wr_q;
  assign bus.s_addr  = addr_q;
  assign bus.s_wdata = wdata_q;

  assign bus.m0_gnt    = gnt_fire && (owner == REQ_IF);
  assign bus.m1_gnt    = gnt_fire && (owner == REQ_MEM);
  assign bus.m0_rvalid = done && (owner == REQ_IF);
  assign bus.m1_rvalid = done && (owner == REQ_MEM);
  assign bus.m0_rdata  = (done && (owner == REQ_IF))  ? bus.s_rdata : '0;
  assign bus.m1_rdata  = (done && (owner == REQ_MEM)) ? bus.s_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed vector bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic clk;
  logic rst;

  mem_port_arbiter_if #(.AW(32), .DW(32)) bus ();

  mem_port_arbiter #(.AW(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        r0, w0; logic [31:0] a0, d0;
    logic        r1, w1; logic [31:0] a1, d1;
    logic        aok, dok; logic [31:0] srd;
    logic        e_sreq;
    logic        e_g0, e_v0; logic [31:0] e_rd0;
    logic        e_g1, e_v1; logic [31:0] e_rd1;
    logic [31:0] e_saddr; logic e_swr; logic [31:0] e_swd;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    logic r0, logic w0, logic [31:0] a0, logic [31:0] d0,
    logic r1, logic w1, logic [31:0] a1, logic [31:0] d1,
    logic aok, logic dok, logic [31:0] srd,
    logic e_sreq, logic e_g0, logic e_v0, logic [31:0] e_rd0,
    logic e_g1, logic e_v1, logic [31:0] e_rd1,
    logic [31:0] e_saddr, logic e_swr, logic [31:0] e_swd);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.aok = aok; v.dok = dok; v.srd = srd;
    v.e_sreq = e_sreq; v.e_g0 = e_g0; v.e_v0 = e_v0; v.e_rd0 = e_rd0;
    v.e_g1 = e_g1; v.e_v1 = e_v1; v.e_rd1 = e_rd1;
    v.e_saddr = e_saddr; v.e_swr = e_swr; v.e_swd = e_swd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.m0_req = v.r0; bus.m0_wr = v.w0; bus.m0_addr = v.a0; bus.m0_wdata = v.d0;
    bus.m1_req = v.r1; bus.m1_wr = v.w1; bus.m1_addr = v.a1; bus.m1_wdata = v.d1;
    bus.s_addr_ok = v.aok; bus.s_data_ok = v.dok; bus.s_rdata = v.srd;
  endtask

  task automatic check_row(input string tag, input vec_t v);
    chk({tag, " s_req"},     {31'd0, bus.s_req},     {31'd0, v.e_sreq});
    chk({tag, " m0_gnt"},    {31'd0, bus.m0_gnt},    {31'd0, v.e_g0});
    chk({tag, " m0_rvalid"}, {31'd0, bus.m0_rvalid}, {31'd0, v.e_v0});
    chk({tag, " m0_rdata"},  bus.m0_rdata,           v.e_rd0);
    chk({tag, " m1_gnt"},    {31'd0, bus.m1_gnt},    {31'd0, v.e_g1});
    chk({tag, " m1_rvalid"}, {31'd0, bus.m1_rvalid}, {31'd0, v.e_v1});
    chk({tag, " m1_rdata"},  bus.m1_rdata,           v.e_rd1);
    chk({tag, " s_addr"},    bus.s_addr,             v.e_saddr);
    chk({tag, " s_wr"},      {31'd0, bus.s_wr},      {31'd0, v.e_swr});
    chk({tag, " s_wdata"},   bus.s_wdata,            v.e_swd);
  endtask

  vec_t idle_v;

  initial begin
    // contention from reset: m1 first, then m0 after one IDLE cycle, third contention to m1
    vecs.push_back(mk(1,0,32'h100,0, 1,0,32'h200,0, 0,0,0,            0, 0,0,0, 0,0,0,            32'h000,0,0));
    vecs.push_back(mk(1,0,32'h100,0, 1,0,32'h200,0, 1,1,32'h1111_1111, 1, 0,0,0, 1,1,32'h1111_1111, 32'h200,0,0));
    vecs.push_back(mk(1,0,32'h100,0, 0,0,0,0,        0,0,0,            0, 0,0,0, 0,0,0,            32'h200,0,0));
    vecs.push_back(mk(1,0,32'h100,0, 0,0,0,0,        1,1,32'h2222_2222, 1, 1,1,32'h2222_2222, 0,0,0, 32'h100,0,0));
    vecs.push_back(mk(1,0,32'h100,0, 1,0,32'h200,0, 0,0,0,            0, 0,0,0, 0,0,0,            32'h100,0,0));
    vecs.push_back(mk(0,0,32'h100,0, 1,0,32'h200,0, 1,0,0,            1, 0,0,0, 1,0,0,            32'h200,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,        1,0,0,            0, 0,0,0, 0,0,0,            32'h200,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,        0,1,32'h3333_3333, 0, 0,0,0, 0,1,32'h3333_3333, 32'h200,0,0));
    // single m0 read with a waiting slave
    vecs.push_back(mk(1,0,32'h40,0,  0,0,0,0,        0,0,0,            0, 0,0,0, 0,0,0,            32'h200,0,0));
    vecs.push_back(mk(1,0,32'h40,0,  0,0,0,0,        0,0,0,            1, 0,0,0, 0,0,0,            32'h040,0,0));
    vecs.push_back(mk(1,0,32'h40,0,  0,0,0,0,        1,0,0,            1, 1,0,0, 0,0,0,            32'h040,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,        0,0,0,            0, 0,0,0, 0,0,0,            32'h040,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,        0,1,32'hDEAD_BEEF, 0, 0,1,32'hDEAD_BEEF, 0,0,0, 32'h040,0,0));
    vecs.push_back(mk(0,0,0,0,       0,0,0,0,        0,0,0,            0, 0,0,0, 0,0,0,            32'h040,0,0));
    // m1 write, fields change after capture
    vecs.push_back(mk(0,0,0,0, 1,1,32'h8,32'h1234_5678,          0,0,0, 0, 0,0,0, 0,0,0, 32'h040,0,0));
    vecs.push_back(mk(0,0,0,0, 1,1,32'h8,32'h1234_5678,          0,0,0, 1, 0,0,0, 0,0,0, 32'h008,1,32'h1234_5678));
    vecs.push_back(mk(0,0,0,0, 1,1,32'hFFFF_FFF0,32'hAAAA_AAAA,  1,0,0, 1, 0,0,0, 1,0,0, 32'h008,1,32'h1234_5678));
    vecs.push_back(mk(0,0,0,0, 0,0,32'hFFFF_FFF0,32'hAAAA_AAAA,  0,0,0, 0, 0,0,0, 0,0,0, 32'h008,1,32'h1234_5678));
    vecs.push_back(mk(0,0,0,0, 0,0,32'hFFFF_FFF0,32'hAAAA_AAAA,  0,1,0, 0, 0,0,0, 0,1,0, 32'h008,1,32'h1234_5678));
    // spurious ok's in IDLE with no requests
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,1,32'hCAFE_F00D, 0, 0,0,0, 0,0,0, 32'h008,1,32'h1234_5678));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 1,1,32'hCAFE_F00D, 0, 0,0,0, 0,0,0, 32'h008,1,32'h1234_5678));
    vecs.push_back(mk(0,0,0,0, 0,0,0,0, 0,0,0,             0, 0,0,0, 0,0,0, 32'h008,1,32'h1234_5678));

    idle_v = mk(0,0,0,0, 0,0,0,0, 0,0,0, 0, 0,0,0, 0,0,0, 0,0,0);

    rst = 1'b1;
    drive(idle_v);
    #7;
    check_row("reset", idle_v);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i]);
      #2;
      check_row($sformatf("vec%0d", i), vecs[i]);
    end

    // reset during DATA abandons the transaction; a late data_ok is ignored
    @(negedge clk);
    bus.m0_req = 1'b1; bus.m0_addr = 32'h300;
    bus.s_addr_ok = 1'b0; bus.s_data_ok = 1'b0;
    @(negedge clk);
    bus.s_addr_ok = 1'b1;
    #2;
    chk("rst_seq m0_gnt", {31'd0, bus.m0_gnt}, 32'd1);
    chk("rst_seq s_addr", bus.s_addr, 32'h300);
    @(negedge clk);
    bus.m0_req = 1'b0; bus.s_addr_ok = 1'b0;
    bus.s_data_ok = 1'b1; bus.s_rdata = 32'h9999_9999;
    #2;
    chk("rst_seq pre m0_rvalid", {31'd0, bus.m0_rvalid}, 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_seq m0_rvalid",  {31'd0, bus.m0_rvalid}, 32'd0);
    chk("rst_seq m0_rdata",   bus.m0_rdata, 32'd0);
    chk("rst_seq s_req",      {31'd0, bus.s_req}, 32'd0);
    chk("rst_seq s_addr rst", bus.s_addr, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.s_addr_ok = 1'b1;
    for (int k = 0; k < 2; k++) begin
      #2;
      chk($sformatf("late%0d m0_rvalid", k), {31'd0, bus.m0_rvalid}, 32'd0);
      chk($sformatf("late%0d m1_rvalid", k), {31'd0, bus.m1_rvalid}, 32'd0);
      chk($sformatf("late%0d m0_gnt", k),    {31'd0, bus.m0_gnt}, 32'd0);
      chk($sformatf("late%0d s_req", k),     {31'd0, bus.s_req}, 32'd0);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
